// File: rtl/seg_display_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seg_display_arbiter                                              |
// | Purpose : Shares one 4-digit display between score, level/message overlays |
// |           and a game-over blink mode; output is saturated and registered.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module seg_display_arbiter #(
  parameter int HOLD_CYCLES  = 80000000,
  parameter int BLINK_CYCLES = 20000000,
  parameter int MAX_VAL      = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] score_val,
  input  logic [13:0] lvl_val,
  input  logic        lvl_req,
  input  logic [13:0] msg_val,
  input  logic        msg_req,
  input  logic        freeze,
  output logic [13:0] disp_num,
  output logic        disp_blank,
  output logic [1:0]  disp_src,
  output logic        lvl_ack,
  output logic        msg_ack
);

  localparam int c_hold_w  = $clog2(HOLD_CYCLES);
  localparam int c_blink_w = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [c_hold_w-1:0]  c_hold_load  = c_hold_w'(HOLD_CYCLES - 1);
  localparam logic [c_blink_w-1:0] c_blink_load = c_blink_w'(BLINK_CYCLES - 1);
  localparam logic [13:0]          c_max_val    = 14'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_SCORE = 2'd0,
    ST_LEVEL = 2'd1,
    ST_MSG   = 2'd2,
    ST_BLINK = 2'd3
  } state_t;

  state_t               r_state;
  logic [13:0]          r_disp_num;
  logic                 r_disp_blank;
  logic                 r_lvl_ack;
  logic                 r_msg_ack;
  logic                 r_lvl_pend;
  logic [13:0]          r_lvl_reg;
  logic [13:0]          r_msg_reg;
  logic [c_hold_w-1:0]  r_hold_cnt;
  logic [c_blink_w-1:0] r_blink_cnt;

  function automatic logic [13:0] sat(input logic [13:0] x);
    return (x > c_max_val) ? c_max_val : x;
  endfunction

  logic [13:0] w_score_sat;
  logic        w_hold_done;
  assign w_score_sat = sat(score_val);
  assign w_hold_done = (r_hold_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_SCORE;
      r_disp_num   <= '0;
      r_disp_blank <= 1'b0;
      r_lvl_ack    <= 1'b0;
      r_msg_ack    <= 1'b0;
      r_lvl_pend   <= 1'b0;
      r_lvl_reg    <= '0;
      r_msg_reg    <= '0;
      r_hold_cnt   <= '0;
      r_blink_cnt  <= '0;
    end else begin
      r_lvl_ack <= 1'b0;
      r_msg_ack <= 1'b0;
      if (r_state != ST_BLINK) begin
        if (lvl_req) r_lvl_reg <= lvl_val;
        if (msg_req) r_msg_reg <= msg_val;
      end

      if (freeze) begin
        // Game over aborts any overlay and drops queued requests.
        r_state    <= ST_BLINK;
        r_disp_num <= w_score_sat;
        r_hold_cnt <= '0;
        r_lvl_pend <= 1'b0;
        if (r_state != ST_BLINK) begin
          r_disp_blank <= 1'b0;
          r_blink_cnt  <= c_blink_load;
        end else if (r_blink_cnt == '0) begin
          r_disp_blank <= ~r_disp_blank;
          r_blink_cnt  <= c_blink_load;
        end else begin
          r_blink_cnt <= r_blink_cnt - c_blink_w'(1);
        end
      end else begin
        r_disp_blank <= 1'b0;
        r_blink_cnt  <= '0;
        case (r_state)
          ST_SCORE: begin
            if (msg_req) begin
              r_state    <= ST_MSG;
              r_hold_cnt <= c_hold_load;
              r_msg_ack  <= 1'b1;
              r_disp_num <= sat(msg_val);
              if (lvl_req) r_lvl_pend <= 1'b1;
            end else if (lvl_req || r_lvl_pend) begin
              r_state    <= ST_LEVEL;
              r_hold_cnt <= c_hold_load;
              r_lvl_ack  <= 1'b1;
              r_lvl_pend <= 1'b0;
              r_disp_num <= lvl_req ? sat(lvl_val) : sat(r_lvl_reg);
            end else begin
              r_disp_num <= w_score_sat;
            end
          end
          ST_LEVEL: begin
            if (msg_req) begin
              // Preempted level overlay is dropped unless re-requested now.
              r_state    <= ST_MSG;
              r_hold_cnt <= c_hold_load;
              r_msg_ack  <= 1'b1;
              r_disp_num <= sat(msg_val);
              r_lvl_pend <= lvl_req;
            end else if (lvl_req) begin
              r_hold_cnt <= c_hold_load;
              r_lvl_ack  <= 1'b1;
              r_disp_num <= sat(lvl_val);
            end else if (w_hold_done) begin
              r_state    <= ST_SCORE;
              r_disp_num <= w_score_sat;
            end else begin
              r_hold_cnt <= r_hold_cnt - c_hold_w'(1);
              r_disp_num <= sat(r_lvl_reg);
            end
          end
          ST_MSG: begin
            if (lvl_req) r_lvl_pend <= 1'b1;
            if (msg_req) begin
              r_hold_cnt <= c_hold_load;
              r_msg_ack  <= 1'b1;
              r_disp_num <= sat(msg_val);
            end else if (w_hold_done) begin
              r_state    <= ST_SCORE;
              r_disp_num <= w_score_sat;
            end else begin
              r_hold_cnt <= r_hold_cnt - c_hold_w'(1);
              r_disp_num <= sat(r_msg_reg);
            end
          end
          default: begin
            r_state    <= ST_SCORE;
            r_disp_num <= w_score_sat;
          end
        endcase
      end
    end
  end

  assign disp_num   = r_disp_num;
  assign disp_blank = r_disp_blank;
  assign disp_src   = r_state;
  assign lvl_ack    = r_lvl_ack;
  assign msg_ack    = r_msg_ack;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seg_display_arbiter                                           |
// | Purpose : Directed scoreboard bench for seg_display_arbiter.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seg_display_arbiter;

  logic        clk;
  logic        reset;
  logic [13:0] score_val;
  logic [13:0] lvl_val;
  logic        lvl_req;
  logic [13:0] msg_val;
  logic        msg_req;
  logic        freeze;
  logic [13:0] disp_num;
  logic        disp_blank;
  logic [1:0]  disp_src;
  logic        lvl_ack;
  logic        msg_ack;

  seg_display_arbiter #(
    .HOLD_CYCLES (8),
    .BLINK_CYCLES(4),
    .MAX_VAL     (9999)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .score_val (score_val),
    .lvl_val   (lvl_val),
    .lvl_req   (lvl_req),
    .msg_val   (msg_val),
    .msg_req   (msg_req),
    .freeze    (freeze),
    .disp_num  (disp_num),
    .disp_blank(disp_blank),
    .disp_src  (disp_src),
    .lvl_ack   (lvl_ack),
    .msg_ack   (msg_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tgt;
    logic [13:0] num;
    logic        blank;
    logic [1:0]  src;
    logic        la;
    logic        ma;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic rst, input int sc, input logic lr, input int lv,
                      input logic mr, input int mv, input logic fz,
                      input int en, input logic eb, input int es,
                      input logic ela, input logic ema, input string nm);
    exp_t e;
    reset     = rst;
    score_val = 14'(sc);
    lvl_req   = lr;
    lvl_val   = 14'(lv);
    msg_req   = mr;
    msg_val   = 14'(mv);
    freeze    = fz;
    e.tgt   = cyc + 1;
    e.num   = 14'(en);
    e.blank = eb;
    e.src   = 2'(es);
    e.la    = ela;
    e.ma    = ema;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  exp_t  m_e;
  string m_nm;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
      m_e  = exp_q.pop_front();
      m_nm = name_q.pop_front();
      n_tests++;
      if (m_e.tgt != cyc ||
          {disp_num, disp_blank, disp_src, lvl_ack, msg_ack} !==
          {m_e.num, m_e.blank, m_e.src, m_e.la, m_e.ma}) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got num=%0d blank=%0b src=%0d lack=%0b mack=%0b, want num=%0d blank=%0b src=%0d lack=%0b mack=%0b",
                 m_nm, cyc, disp_num, disp_blank, disp_src, lvl_ack, msg_ack,
                 m_e.num, m_e.blank, m_e.src, m_e.la, m_e.ma);
      end
    end
  end

  initial begin
    reset = 1'b1; score_val = '0; lvl_val = '0; lvl_req = 1'b0;
    msg_val = '0; msg_req = 1'b0; freeze = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset values, score tracking and saturation
    step(1, 1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    step(0, 1234, 0, 0, 0, 0, 0, 1234, 0, 0, 0, 0, "score");
    step(0, 12000, 0, 0, 0, 0, 0, 9999, 0, 0, 0, 0, "score_sat");
    step(0, 9999, 0, 0, 0, 0, 0, 9999, 0, 0, 0, 0, "score_max");
    step(0, 10000, 0, 0, 0, 0, 0, 9999, 0, 0, 0, 0, "score_max1");
    step(0, 500, 0, 0, 0, 0, 0, 500, 0, 0, 0, 0, "score_500");

    // 2: level overlay held for exactly 8 cycles
    step(0, 500, 1, 7, 0, 0, 0, 7, 0, 1, 1, 0, "lvl_start");
    for (int i = 0; i < 7; i++) step(0, 500, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, "lvl_hold");
    step(0, 500, 0, 0, 0, 0, 0, 500, 0, 0, 0, 0, "lvl_end");
    step(0, 500, 0, 0, 0, 0, 0, 500, 0, 0, 0, 0, "lvl_after");

    // 3: simultaneous requests, message first then queued level
    step(0, 500, 1, 3, 1, 40, 0, 40, 0, 2, 0, 1, "both_msg");
    for (int i = 0; i < 7; i++) step(0, 500, 0, 0, 0, 0, 0, 40, 0, 2, 0, 0, "both_msg_hold");
    step(0, 500, 0, 0, 0, 0, 0, 500, 0, 0, 0, 0, "both_gap");
    step(0, 500, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0, "both_lvl");
    for (int i = 0; i < 7; i++) step(0, 500, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, "both_lvl_hold");
    step(0, 500, 0, 0, 0, 0, 0, 500, 0, 0, 0, 0, "both_end");

    // 4: message preempts level in its 3rd cycle; level not re-queued
    step(0, 500, 1, 2, 0, 0, 0, 2, 0, 1, 1, 0, "pre_lvl");
    step(0, 500, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, "pre_lvl2");
    step(0, 500, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, "pre_lvl3");
    step(0, 500, 0, 0, 1, 5, 0, 5, 0, 2, 0, 1, "pre_msg");
    for (int i = 0; i < 7; i++) step(0, 500, 0, 0, 0, 0, 0, 5, 0, 2, 0, 0, "pre_msg_hold");
    for (int i = 0; i < 3; i++) step(0, 500, 0, 0, 0, 0, 0, 500, 0, 0, 0, 0, "pre_no_lvl");

    // level restart and overlay saturation
    step(0, 500, 1, 16000, 0, 0, 0, 9999, 0, 1, 1, 0, "lvl_sat");
    step(0, 500, 0, 0, 0, 0, 0, 9999, 0, 1, 0, 0, "lvl_sat2");
    step(0, 500, 1, 9, 0, 0, 0, 9, 0, 1, 1, 0, "lvl_restart");
    for (int i = 0; i < 7; i++) step(0, 500, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, "lvl_restart_hold");
    step(0, 500, 0, 0, 0, 0, 0, 500, 0, 0, 0, 0, "lvl_restart_end");

    // 5: freeze mid-message, blink pattern, requests ignored
    step(0, 600, 0, 0, 1, 77, 0, 77, 0, 2, 0, 1, "frz_msg");
    step(0, 600, 0, 0, 0, 0, 0, 77, 0, 2, 0, 0, "frz_msg2");
    for (int i = 0; i < 14; i++)
      step(0, (i < 6) ? 600 : 601, (i == 2), 55, (i == 9), 66, 1,
           (i < 6) ? 600 : 601, ((i / 4) % 2) == 1, 3, 0, 0, "blink");
    step(0, 601, 0, 0, 0, 0, 0, 601, 0, 0, 0, 0, "unfreeze");
    for (int i = 0; i < 3; i++) step(0, 601, 0, 0, 0, 0, 0, 601, 0, 0, 0, 0, "post_blink");

    // 6: reset mid-overlay with a pending level, then mid-blink
    step(0, 700, 1, 3, 1, 40, 0, 40, 0, 2, 0, 1, "rst_ovl_msg");
    step(0, 700, 0, 0, 0, 0, 0, 40, 0, 2, 0, 0, "rst_ovl_msg2");
    step(1, 700, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, "rst_ovl");
    for (int i = 0; i < 12; i++) step(0, 700, 0, 0, 0, 0, 0, 700, 0, 0, 0, 0, "rst_no_pend");
    for (int i = 0; i < 5; i++)
      step(0, 700, 0, 0, 0, 0, 1, 700, (i == 4), 3, 0, 0, "rst_blink_pre");
    step(1, 700, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "rst_blink");
    step(0, 700, 0, 0, 0, 0, 0, 700, 0, 0, 0, 0, "rst_blink_after");

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
